// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter: FSM state encoding,
// timeout response word and slave-select codes.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] SPI_TO_RESP = 16'hEEEE;

  localparam logic [2:0] SS_CH1  = 3'b000;
  localparam logic [2:0] SS_CH2  = 3'b001;
  localparam logic [2:0] SS_CH3  = 3'b010;
  localparam logic [2:0] SS_TRIG = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

endpackage

// File: rtl/spi_arb_sel.sv
// Winner select between the two requesters. With SPI_ARB_RR_EN defined a
// round-robin pointer breaks ties; otherwise req0 has fixed priority.
module spi_arb_sel (
`ifdef SPI_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic vld0,
  input  logic vld1,
  output logic any,
  output logic idx
);

  assign any = vld0 | vld1;

`ifdef SPI_ARB_RR_EN
  logic ptr;

  // ptr names the preferred requester; a lone requester wins regardless
  always_comb begin
    if (vld0 && vld1) idx = ptr;
    else              idx = vld1;
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (take) ptr <= ~idx;
  end
`else
  assign idx = ~vld0;
`endif

endmodule

// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of the SPI master: grants one transaction at a
// time, launches it, waits for SPI_done (with timeout) and returns the read word.
// Optional round-robin arbitration via `define SPI_ARB_RR_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [2:0]  req0_ss,
  input  logic [15:0] req0_data,
  input  logic        req1_vld,
  input  logic [2:0]  req1_ss,
  input  logic [15:0] req1_data,
  output logic        req0_done,
  output logic        req1_done,
  output logic [15:0] rsp_data,
  output logic        wrt_SPI,
  output logic [15:0] SPI_data,
  output logic [2:0]  ss,
  input  logic        SPI_done,
  input  logic [15:0] SPI_rd_data,
  output logic        busy,
  output logic        timeout_err,
  output state_t      state_dbg
);

  // Handshake: a requester raises reqN_vld with stable ss/data and holds it
  // until its one-cycle reqN_done; requests are sampled only in IDLE.
  state_t            state, state_nxt;
  logic              owner;
  logic [TO_W-1:0]   to_cnt;
  logic              grant_any, grant_idx;
  logic              timeout_hit;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign state_dbg   = state;

  spi_arb_sel u_sel (
`ifdef SPI_ARB_RR_EN
    .clk  (clk),
    .rst  (rst),
    .take ((state == IDLE) && grant_any),
`endif
    .vld0 (req0_vld),
    .vld1 (req1_vld),
    .any  (grant_any),
    .idx  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = BUSY;
      BUSY:    if (SPI_done || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wrt_SPI   = (state == LAUNCH);
    busy      = (state != IDLE);
    req0_done = (state == DONE) && !owner;
    req1_done = (state == DONE) &&  owner;
  end

  // ss/SPI_data keep the last transaction's values between transactions
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= 1'b0;
      ss          <= SS_CH1;
      SPI_data    <= 16'h0000;
      rsp_data    <= 16'h0000;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner    <= grant_idx;
            ss       <= grant_idx ? req1_ss   : req0_ss;
            SPI_data <= grant_idx ? req1_data : req0_data;
          end
        end
        LAUNCH: to_cnt <= '0;
        BUSY: begin
          // a real completion takes precedence over a same-cycle timeout
          if (SPI_done) begin
            rsp_data <= SPI_rd_data;
          end else if (timeout_hit) begin
            rsp_data    <= SPI_TO_RESP;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a bench-side SPI master responder, a
// scoreboard queue of {owner, rsp_data} checked on every done pulse.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int T  = 40;
  localparam int TW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req1_vld;
  logic [2:0]  req0_ss, req1_ss;
  logic [15:0] req0_data, req1_data;
  logic        req0_done, req1_done;
  logic [15:0] rsp_data;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        SPI_done;
  logic [15:0] SPI_rd_data;
  logic        busy, timeout_err;
  state_t      state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  logic        exp_to;
`ifdef SPI_ARB_RR_EN
  logic        rr_ptr;
`endif

  // clock / reset
  always #5 clk = ~clk;

  spi_arbiter #(.TIMEOUT_CYC(T), .TO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_ss(req0_ss), .req0_data(req0_data),
    .req1_vld(req1_vld), .req1_ss(req1_ss), .req1_data(req1_data),
    .req0_done(req0_done), .req1_done(req1_done), .rsp_data(rsp_data),
    .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .ss(ss),
    .SPI_done(SPI_done), .SPI_rd_data(SPI_rd_data),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every done pulse must match the oldest expected completion
  always @(negedge clk) begin : sb
    logic [16:0] e;
    if (!rst && (req0_done || req1_done)) begin
      chk("single_done", {31'b0, req0_done & req1_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("done_owner", {31'b0, req1_done}, {31'b0, e[16]});
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, e[15:0]});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_wrt(input int exp_cyc);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!wrt_SPI && c < 8);
    chk("wrt_latency", c, exp_cyc);
  endtask

  function automatic logic pick();
`ifdef SPI_ARB_RR_EN
    if (req0_vld && req1_vld) return rr_ptr;
    return req1_vld;
`else
    return !req0_vld;
`endif
  endfunction

  // lat > T withholds SPI_done entirely; stray pulses SPI_done during LAUNCH
  task automatic serve(input logic who, input int lat, input logic [15:0] rd,
                       input int wcyc, input bit stray);
    logic [2:0]  s;
    logic [15:0] d;
    s = who ? req1_ss : req0_ss;
    d = who ? req1_data : req0_data;
    wait_wrt(wcyc);
`ifdef SPI_ARB_RR_EN
    rr_ptr = ~who;
`endif
    chk("ss", {29'b0, ss}, {29'b0, s});
    chk("spi_data", {16'b0, SPI_data}, {16'b0, d});
    chk("busy_launch", {31'b0, busy}, 32'd1);
    if (stray) begin
      SPI_done    = 1'b1;
      SPI_rd_data = 16'hDEAD;
    end
    if (lat > T) begin
      repeat (T) begin
        tick();
        SPI_done = 1'b0;
      end
      chk("no_early_done", {30'b0, req0_done, req1_done}, 32'd0);
      exp_q.push_back({who, SPI_TO_RESP});
      exp_to = 1'b1;
      tick();
    end else begin
      repeat (lat) begin
        tick();
        SPI_done = 1'b0;
      end
      SPI_done    = 1'b1;
      SPI_rd_data = rd;
      exp_q.push_back({who, rd});
      tick();
      SPI_done = 1'b0;
    end
    chk("done_pulse", {31'b0, who ? req1_done : req0_done}, 32'd1);
    chk("timeout_err", {31'b0, timeout_err}, {31'b0, exp_to});
    if (who) req1_vld = 1'b0;
    else     req0_vld = 1'b0;
  endtask

  task automatic raise(input logic who);
    if (who) begin
      req1_ss = 3'($urandom_range(0, 4)); req1_data = 16'($urandom); req1_vld = 1'b1;
    end else begin
      req0_ss = 3'($urandom_range(0, 4)); req0_data = 16'($urandom); req0_vld = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wrt"},   {31'b0, wrt_SPI}, 32'd0);
    chk({tag, "_done"},  {30'b0, req0_done, req1_done}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    chk({tag, "_toerr"}, {31'b0, timeout_err}, 32'd0);
    chk({tag, "_data"},  {16'b0, SPI_data}, 32'd0);
    chk({tag, "_ss"},    {29'b0, ss}, 32'd0);
    chk({tag, "_rsp"},   {16'b0, rsp_data}, 32'd0);
    chk({tag, "_state"}, {30'b0, state_dbg}, {30'b0, IDLE});
  endtask

  initial begin
    logic w;
    rst = 1'b1; SPI_done = 1'b0; SPI_rd_data = 16'h0;
    req0_vld = 1'b0; req0_ss = 3'b0; req0_data = 16'h0;
    req1_vld = 1'b0; req1_ss = 3'b0; req1_data = 16'h0;
    exp_to = 1'b0;
`ifdef SPI_ARB_RR_EN
    rr_ptr = 1'b0;
`endif
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // single req0 to the EEPROM
    req0_ss = SS_EEP; req0_data = 16'h0015; req0_vld = 1'b1;
    serve(1'b0, 8, 16'h00A7, 1, 1'b0);
    tick();
    chk("idle_after_t1", {30'b0, state_dbg}, {30'b0, IDLE});

    // contention: both valid in the same cycle, three rounds, then drain
    for (int r = 0; r < 3; r++) begin
      if (!req0_vld) raise(1'b0);
      if (!req1_vld) raise(1'b1);
      w = pick();
      serve(w, int'($urandom_range(1, 6)), 16'($urandom), 1, 1'b0);
      tick();
    end
    if (req0_vld || req1_vld) begin
      w = pick();
      serve(w, 3, 16'($urandom), 1, 1'b0);
      tick();
    end

    // timeout on req1, then a good transaction keeps timeout_err set
    raise(1'b1);
    serve(1'b1, T + 5, 16'h0, 1, 1'b0);
    tick();
    raise(1'b0);
    serve(1'b0, 2, 16'h0C3C, 1, 1'b0);
    tick();

    // reset while BUSY abandons the transaction
    raise(1'b0);
    wait_wrt(1);
    repeat (3) tick();
    chk("pre_rst_state", {30'b0, state_dbg}, {30'b0, BUSY});
    rst = 1'b1;
    req0_vld = 1'b0;
    tick();
    chk_reset_vals("midrst");
    exp_to = 1'b0;
`ifdef SPI_ARB_RR_EN
    rr_ptr = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) tick();
    chk("no_done_after_rst", {30'b0, req0_done, req1_done}, 32'd0);
    raise(1'b1);
    serve(1'b1, 5, 16'h7E81, 1, 1'b0);
    tick();

    // SPI_done lands exactly on the timeout cycle
    raise(1'b0);
    serve(1'b0, T, 16'h1234, 1, 1'b0);
    tick();

    // stray SPI_done in IDLE, then in LAUNCH
    SPI_done = 1'b1; SPI_rd_data = 16'hBEEF;
    tick();
    SPI_done = 1'b0;
    chk("stray_idle_done", {30'b0, req0_done, req1_done}, 32'd0);
    chk("stray_idle_rsp", {16'b0, rsp_data}, 32'h1234);
    chk("stray_idle_state", {30'b0, state_dbg}, {30'b0, IDLE});
    tick();
    chk("stray_idle_done2", {30'b0, req0_done, req1_done}, 32'd0);
    raise(1'b1);
    serve(1'b1, 4, 16'h5A5A, 1, 1'b1);
    tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
